// File: rtl/capture_sequencer.sv
// ------------------------------------------------------------------
// capture_sequencer: arm / trigger / capture / readout control FSM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module capture_sequencer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             auto_rearm,
  input  logic [CNT_W-1:0] post_len,
  input  logic             sample_valid,
  input  logic             trigger_hit,
  input  logic             FIFO_wrfull,
  input  logic             FIFO_rdempty,
  input  logic             readout_idle,
  output logic             FIFO_wrreq,
  output logic             triggerBlock_Syncrst,
  output logic [CNT_W-1:0] sample_count,
  output logic             truncated,
  output logic             capture_done,
  output logic [4:0]       state_debug
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_CLEAR   = 5'b00010,
    S_ARMED   = 5'b00100,
    S_CAPTURE = 5'b01000,
    S_READOUT = 5'b10000
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             len_nz;
  logic             done_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    len_d                = len_q;
    cnt_d                = cnt_q;
    trunc_d              = trunc_q;
    FIFO_wrreq           = 1'b0;
    triggerBlock_Syncrst = 1'b0;
    capture_done         = 1'b0;
    done_write           = 1'b0;
    len_nz               = (len_q != '0);
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    cnt_inc              = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (arm && !abort) begin
          state_d = S_CLEAR;
          len_d   = post_len;
          cnt_d   = '0;
          trunc_d = 1'b0;
        end
      end
      S_CLEAR: begin
        triggerBlock_Syncrst = 1'b1;
        state_d = abort ? S_IDLE : S_ARMED;
      end
      S_ARMED: begin
        if (abort)
          state_d = S_IDLE;
        else if (trigger_hit)
          state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        FIFO_wrreq = sample_valid & ~FIFO_wrfull;
        if (FIFO_wrreq)
          cnt_d = cnt_inc;
        done_write = FIFO_wrreq && len_nz && (cnt_inc == len_q);
        if (abort) begin
          state_d = S_IDLE;
        end else if (done_write) begin
          state_d = S_READOUT;
        end else if (FIFO_wrfull) begin
          state_d = S_READOUT;
          trunc_d = len_nz && (cnt_q < len_q);
        end
      end
      S_READOUT: begin
        // abort is deliberately not honoured here; the readout must drain.
        if (FIFO_rdempty && readout_idle) begin
          capture_done = 1'b1;
          if (auto_rearm) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            trunc_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sample_count = cnt_q;
  assign truncated    = trunc_q;
  assign state_debug  = state_q;

endmodule

`default_nettype wire
